bus_arbiter_ctrl: RTL

- Sequences a shared 8-bit bidirectional data bus (tri-state bus_control instance) to a 32-entry memory.
- Arbitrates between NUM_REQ requesters, round-robin.
- Generates the bus drive enable (ctrl_signal), memory address, write and output-enable strobes.
- Inserts a mandatory turnaround cycle so the controller and the memory never drive the bus in the same cycle.
- Sits between requester logic and the bus_control / memory pair.

---
 rtl/bus_ctrl_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/bus_arbiter_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bus_ctrl_pkg.sv
// Shared types and defaults for the bus arbiter / sequencer.
package bus_ctrl_pkg;

  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned ADDR_WIDTH  = 5;
  localparam int unsigned TURN_CYCLES = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CAP,
    TURN
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester pick with a registered rotating priority pointer.
module rr_arbiter #(
  parameter int unsigned  NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  // First asserted request at or above the pointer, wrapping around.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    onehot[idx] = valid;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && valid) begin
      ptr_d = (32'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bus_arbiter_ctrl.sv
// Arbitrates requesters onto a shared tri-state bus to a small memory, with a
// turnaround cycle after every transfer so the two drivers never overlap.
module bus_arbiter_ctrl #(
  parameter int unsigned DATA_WIDTH = bus_ctrl_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = bus_ctrl_pkg::ADDR_WIDTH,
  parameter int unsigned NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_we,
  output logic                          mem_oe,
  output logic                          ctrl_signal,
  output logic [DATA_WIDTH-1:0]         data_tx,
  input  logic [DATA_WIDTH-1:0]         data_rx
);

  import bus_ctrl_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [NUM_REQ-1:0]    gnt_d, done_d;
  logic [DATA_WIDTH-1:0] rdata_d, data_tx_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  mem_we_d, mem_oe_d, ctrl_d;

  logic [NUM_REQ-1:0]    arb_onehot;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (state_q == IDLE),
    .onehot (arb_onehot),
    .idx    (arb_idx),
    .valid  (arb_valid)
  );

  // Outputs are registered from the current state, so each state's strobes
  // appear during the cycle after the state is entered.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    gnt_d      = '0;
    done_d     = '0;
    mem_we_d   = 1'b0;
    mem_oe_d   = 1'b0;
    ctrl_d     = 1'b0;
    mem_addr_d = mem_addr;
    data_tx_d  = data_tx;
    rdata_d    = rdata;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_onehot;
          owner_d = arb_idx;
          we_d    = we[arb_idx];
          addr_d  = addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          state_d = we[arb_idx] ? WR : RD;
        end
      end
      WR: begin
        ctrl_d     = 1'b1;
        mem_we_d   = 1'b1;
        data_tx_d  = wdata_q;
        mem_addr_d = addr_q;
        state_d    = TURN;
      end
      RD: begin
        mem_oe_d   = 1'b1;
        mem_addr_d = addr_q;
        state_d    = CAP;
      end
      CAP: begin
        mem_oe_d = 1'b1;
        state_d  = TURN;
      end
      TURN: begin
        done_d[owner_q] = 1'b1;
        // mem_oe is still high this cycle, so the bus carries the read value.
        if (!we_q) begin
          rdata_d = data_rx;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt         <= '0;
      done        <= '0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
      ctrl_signal <= 1'b0;
      mem_addr    <= '0;
      data_tx     <= '0;
      rdata       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gnt         <= gnt_d;
      done        <= done_d;
      mem_we      <= mem_we_d;
      mem_oe      <= mem_oe_d;
      ctrl_signal <= ctrl_d;
      mem_addr    <= mem_addr_d;
      data_tx     <= data_tx_d;
      rdata       <= rdata_d;
    end
  end

endmodule
